// File: rtl/bsg_mem_1rw_sync_ctrl_pkg.sv
// Shared types and constants for the 1rw sync memory controller.
// Also supplies BSG_SAFE_CLOG2 when the basejump macro header is absent.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2((x)))
`endif

package bsg_mem_1rw_sync_ctrl_pkg;

  typedef enum logic [0:0] {
    StInit  = 1'b0,
    StReady = 1'b1
  } state_e;

  localparam int unsigned resp_fifo_depth_gp     = 3;
  localparam int unsigned resp_fifo_ptr_width_gp = $clog2(resp_fifo_depth_gp);
  localparam int unsigned resp_fifo_cnt_width_gp = $clog2(resp_fifo_depth_gp + 1);

  // Circular pointer increment for a non-power-of-two ring.
  function automatic logic [resp_fifo_ptr_width_gp-1:0] resp_fifo_ptr_inc(
    input logic [resp_fifo_ptr_width_gp-1:0] ptr
  );
    if (ptr == resp_fifo_ptr_width_gp'(resp_fifo_depth_gp - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_ctrl_resp_fifo.sv
// Response FIFO: width_p x 3 ring buffer, valid/yumi dequeue, occupancy count.
// The enqueuer guarantees it never pushes into a full buffer.

module bsg_mem_1rw_sync_ctrl_resp_fifo
  import bsg_mem_1rw_sync_ctrl_pkg::*;
#(
  parameter int width_p = -1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              v_i,
  input  logic [width_p-1:0]                data_i,
  output logic                              v_o,
  output logic [width_p-1:0]                data_o,
  input  logic                              yumi_i,
  output logic [resp_fifo_cnt_width_gp-1:0] count_o
);

  logic [width_p-1:0]                storage [resp_fifo_depth_gp];
  logic [resp_fifo_ptr_width_gp-1:0] rd_ptr_q, rd_ptr_d;
  logic [resp_fifo_ptr_width_gp-1:0] wr_ptr_q, wr_ptr_d;
  logic [resp_fifo_cnt_width_gp-1:0] count_q, count_d;
  logic                              enq;
  logic                              deq;

  assign enq     = v_i;
  assign v_o     = (count_q != '0);
  assign deq     = yumi_i & v_o;
  assign data_o  = storage[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count next-state; push+pop together leaves the count alone.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = resp_fifo_ptr_inc(wr_ptr_q);
    if (deq) rd_ptr_d = resp_fifo_ptr_inc(rd_ptr_q);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the buffer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; only entries below count are observable.
  always_ff @(posedge clk_i) begin
    if (enq) storage[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_mem_1rw_sync_ctrl.sv
// Client-side controller for a 1rw synchronous memory with a buffered read path.
// Optional zero-fill sweep after reset: define BSG_MEM_1RW_SYNC_CTRL_INIT_EN.

module bsg_mem_1rw_sync_ctrl
  import bsg_mem_1rw_sync_ctrl_pkg::*;
#(
  parameter  int width_p       = -1,
  parameter  int els_p         = -1,
  localparam int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  input  logic                     req_w_i,
  input  logic [addr_width_lp-1:0] req_addr_i,
  input  logic [width_p-1:0]       req_data_i,
  output logic                     req_ready_o,
  output logic                     resp_v_o,
  output logic [width_p-1:0]       resp_data_o,
  input  logic                     resp_yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     init_done_o
);

  localparam int unsigned occ_width_lp = resp_fifo_cnt_width_gp + 1;

  state_e                            state;
  logic                              inflight_q;
  logic                              accept;
  logic                              fifo_v;
  logic [resp_fifo_cnt_width_gp-1:0] fifo_count;
  logic [occ_width_lp-1:0]           occupancy;

`ifdef BSG_MEM_1RW_SYNC_CTRL_INIT_EN
  state_e                   state_q, state_d;
  logic [addr_width_lp-1:0] init_cnt_q, init_cnt_d;

  // Sweep every address once, then hand over to READY until the next reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == addr_width_lp'(els_p - 1)) state_d = StReady;
      end
      StReady: ;
    endcase
  end

  // State and sweep counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign state = state_q;
`else
  assign state = StReady;
`endif

  // Reads in flight count against FIFO space so a response always has a slot.
  assign occupancy   = {1'b0, fifo_count} + occ_width_lp'(inflight_q);
  assign req_ready_o = ~reset_i & (state == StReady)
                     & (occupancy < occ_width_lp'(resp_fifo_depth_gp));
  assign accept      = req_v_i & req_ready_o;
  assign init_done_o = ~reset_i & (state == StReady);
  assign resp_v_o    = ~reset_i & fifo_v;

  // Memory port: client pass-through in READY, zero-fill writes in INIT.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (!reset_i) begin
      mem_v_o    = accept;
      mem_w_o    = req_w_i;
      mem_addr_o = req_addr_i;
      mem_data_o = req_data_i;
`ifdef BSG_MEM_1RW_SYNC_CTRL_INIT_EN
      if (state_q == StInit) begin
        mem_v_o    = 1'b1;
        mem_w_o    = 1'b1;
        mem_addr_o = init_cnt_q;
        mem_data_o = '0;
      end
`endif
    end
  end

  // Marks the cycle in which mem_data_i carries the previous read's data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) inflight_q <= 1'b0;
    else         inflight_q <= accept & ~req_w_i;
  end

  bsg_mem_1rw_sync_ctrl_resp_fifo #(
    .width_p (width_p)
  ) resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (inflight_q),
    .data_i  (mem_data_i),
    .v_o     (fifo_v),
    .data_o  (resp_data_o),
    .yumi_i  (resp_yumi_i),
    .count_o (fifo_count)
  );

endmodule
